mm_stream_loader: RTL and testbench
===================================

MM_STREAM_LOADER -- requirements
Module: mm_stream_loader

Interface
REQ-001 Parameters SHALL be: width 8, element bits; A_depth_bits 9, A0/A1 address bits; B_depth_bits 9, B0/B1 address bits; RES_depth_bits 9, RES address bits; M 64, rows of A; N 8, inner dimension (even); P 2, columns of B.
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 s_data in width, s_valid in 1, s_ready out 1, s_last in 1: input stream carrying A then B, row-major; beat accepted when s_valid&&s_ready.
REQ-005 m_data out width, m_valid out 1, m_ready in 1, m_last out 1: result stream carrying RES, row-major; beat transferred when m_valid&&m_ready.
REQ-006 A0_write_en/A1_write_en out 1, A0_write_address/A1_write_address out A_depth_bits, A0_write_data_in/A1_write_data_in out width: A bank write ports.
REQ-007 B0_write_en/B1_write_en out 1, B0_write_address/B1_write_address out B_depth_bits, B0_write_data_in/B1_write_data_in out width: B bank write ports.
REQ-008 Start out 1, Done in 1: handshake to the matrix-multiply core.
REQ-009 RES_read_en out 1, RES_read_address out RES_depth_bits, RES_read_data_out in width: RES read port, synchronous, data valid 1 cycle after address.
REQ-010 err out 1: sticky stream-framing error flag (see Configuration).

Function
REQ-011 States SHALL be RECV_A -> RECV_B -> COMPUTE -> SEND -> RECV_A.
REQ-012 RECV_A: s_ready=1; beat n (0..M*N-1) SHALL map to i=n/N, j=n%N; j<N/2 -> A0 addr i*N/2+j; else A1 addr i*N/2+(j-N/2); write enable asserted in the same cycle as acceptance, exactly one bank written per beat.
REQ-013 RECV_B: s_ready=1; beat n (0..N*P-1) SHALL map to j=n/P, k=n%P; j<N/2 -> B0 addr j*P+k; else B1 addr (j-N/2)*P+k.
REQ-014 Transitions RECV_A->RECV_B and RECV_B->COMPUTE SHALL occur on acceptance of the final beat of each matrix; s_valid gaps SHALL stall counters without writes.
REQ-015 COMPUTE: s_ready=0; Start SHALL rise in the first COMPUTE cycle and stay high until Done is sampled high, then fall on the next edge together with entry to SEND.
REQ-016 SEND: M*P words SHALL be read from RES addresses 0..M*P-1 in order and emitted on m_data; m_last=1 only on word M*P-1.
REQ-017 SEND output SHALL use a 2-entry buffer: m_data/m_last stable while m_valid&&!m_ready; no word dropped or duplicated; with m_ready held high, sustained 1 word/cycle, first m_valid 2 cycles after SEND entry.
REQ-018 RES_read_en SHALL assert only when a buffer slot is guaranteed free at data return.
REQ-019 After the last m_valid&&m_ready, state SHALL return to RECV_A, all counters cleared; s_ready=0 in COMPUTE and SEND.
REQ-020 All write enables SHALL be 0 outside RECV_A/RECV_B and during non-accepting cycles.

Reset
REQ-021 resetn low SHALL immediately force state RECV_A, counters 0, Start 0, all write enables 0, RES_read_en 0, m_valid 0, m_last 0, err 0, buffer empty; addresses/data 0.
REQ-022 s_ready SHALL be 0 while resetn is low and 1 from the first edge after release.
REQ-023 Reset mid-operation (any state) SHALL abandon the transfer; no partial-frame state survives.

Configuration
REQ-024 Macro S_LAST_CHECK_EN defined: s_last SHALL be 1 exactly on final A beat and final B beat; any mismatch sets err (sticky until reset), data still written, counting unaffected.
REQ-025 Macro undefined: s_last ignored, err tied 0.

Verification (M=2, N=4, P=2)
REQ-026 Stream A=1..8, B=9..16, s_valid constant -> A0 addr0..3 = 1,2,5,6; A1 = 3,4,7,8; B0 addr0..3 = 9..12; B1 = 13..16.
REQ-027 Core model asserts Done 5 cycles after Start -> Start high exactly 5 cycles, falls next edge, SEND entered same edge.
REQ-028 RES preloaded 0xA0..0xA3, m_ready=1 -> m_data A0,A1,A2,A3 on consecutive cycles, m_last only with A3.
REQ-029 m_ready toggled 1,0,0,1,0,1... -> each word held while stalled, exact sequence A0..A3, no duplicates.
REQ-030 resetn pulsed low during RECV_B beat 3 -> outputs at reset values immediately; fresh full frame then processed correctly.
REQ-031 S_LAST_CHECK_EN defined, s_last on A beat 6 -> err=1 from next cycle, remains 1; undefined -> err stays 0.

Source files
------------

// File: rtl/mm_stream_loader.sv
// Streams A and B into banked operand RAMs, runs the multiply core, then streams RES back out.
// Optional build macro S_LAST_CHECK_EN enables the sticky s_last framing check on err.
module mm_stream_loader #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 9,
    parameter int RES_depth_bits = 9,
    parameter int M              = 64,
    parameter int N              = 8,
    parameter int P              = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [width-1:0]          s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      s_last,
    output logic [width-1:0]          m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      A0_write_en,
    output logic [A_depth_bits-1:0]   A0_write_address,
    output logic [width-1:0]          A0_write_data_in,
    output logic                      A1_write_en,
    output logic [A_depth_bits-1:0]   A1_write_address,
    output logic [width-1:0]          A1_write_data_in,
    output logic                      B0_write_en,
    output logic [B_depth_bits-1:0]   B0_write_address,
    output logic [width-1:0]          B0_write_data_in,
    output logic                      B1_write_en,
    output logic [B_depth_bits-1:0]   B1_write_address,
    output logic [width-1:0]          B1_write_data_in,
    output logic                      Start,
    input  logic                      Done,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    output logic                      err
);

    localparam int A_BEATS = M * N;
    localparam int B_BEATS = N * P;
    localparam int HALF    = N / 2;
    localparam int B_HALF  = HALF * P;
    localparam int R_WORDS = M * P;
    localparam int AW      = $clog2(A_BEATS);
    localparam int BW      = $clog2(B_BEATS);
    localparam int JW      = $clog2(N);
    localparam int RW      = $clog2(R_WORDS + 1);

    typedef enum logic [1:0] {
        RECV_A  = 2'd0,
        RECV_B  = 2'd1,
        COMPUTE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 rdy_r;

    logic [AW-1:0]        a_cnt_r;
    logic [JW-1:0]        j_r;
    logic [A_depth_bits-1:0] a0_addr_r;
    logic [A_depth_bits-1:0] a1_addr_r;
    logic [BW-1:0]        b_cnt_r;
    logic                 start_r;

    logic [RW-1:0]        rd_cnt_r;
    logic [RW-1:0]        out_cnt_r;
    logic                 rd_pend_r;
    logic [width-1:0]     buf_r [0:1];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           occ_r;

    logic                 accept_s;
    logic                 a_acc_s;
    logic                 b_acc_s;
    logic                 a_last_s;
    logic                 b_last_s;
    logic                 a_lo_s;
    logic                 b_lo_s;
    logic [BW-1:0]        b_off_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 rd_en_s;
    logic                 send_done_s;

    assign s_ready  = rdy_r && ((state_r == RECV_A) || (state_r == RECV_B));
    assign accept_s = s_valid && s_ready;
    assign a_acc_s  = accept_s && (state_r == RECV_A);
    assign b_acc_s  = accept_s && (state_r == RECV_B);
    assign a_last_s = (a_cnt_r == AW'(A_BEATS - 1));
    assign b_last_s = (b_cnt_r == BW'(B_BEATS - 1));
    assign a_lo_s   = (j_r < JW'(HALF));
    assign b_lo_s   = (b_cnt_r < BW'(B_HALF));
    assign b_off_s  = b_cnt_r - BW'(B_HALF);

    // Each bank receives a contiguous run of addresses, so per-bank address counters suffice.
    assign A0_write_en      = a_acc_s && a_lo_s;
    assign A1_write_en      = a_acc_s && !a_lo_s;
    assign B0_write_en      = b_acc_s && b_lo_s;
    assign B1_write_en      = b_acc_s && !b_lo_s;
    assign A0_write_address = A0_write_en ? a0_addr_r : {A_depth_bits{1'b0}};
    assign A1_write_address = A1_write_en ? a1_addr_r : {A_depth_bits{1'b0}};
    assign B0_write_address = B0_write_en ? B_depth_bits'(b_cnt_r) : {B_depth_bits{1'b0}};
    assign B1_write_address = B1_write_en ? B_depth_bits'(b_off_s) : {B_depth_bits{1'b0}};
    assign A0_write_data_in = A0_write_en ? s_data : {width{1'b0}};
    assign A1_write_data_in = A1_write_en ? s_data : {width{1'b0}};
    assign B0_write_data_in = B0_write_en ? s_data : {width{1'b0}};
    assign B1_write_data_in = B1_write_en ? s_data : {width{1'b0}};

    assign m_valid     = (occ_r != 2'd0);
    assign m_data      = buf_r[rd_ptr_r];
    assign m_last      = m_valid && (out_cnt_r == RW'(R_WORDS - 1));
    assign pop_s       = m_valid && m_ready;
    assign push_s      = rd_pend_r;
    assign send_done_s = pop_s && (out_cnt_r == RW'(R_WORDS - 1));
    assign Start       = start_r;

    // A read may issue only if its returning word is sure to find a free slot next cycle.
    assign rd_en_s = (state_r == SEND) && (rd_cnt_r < RW'(R_WORDS)) &&
                     ((3'(occ_r) + 3'(rd_pend_r)) <= (3'd1 + 3'(pop_s)));
    assign RES_read_en      = rd_en_s;
    assign RES_read_address = rd_en_s ? RES_depth_bits'(rd_cnt_r) : {RES_depth_bits{1'b0}};

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= RECV_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RECV_A: begin
                if (a_acc_s && a_last_s) begin
                    state_nxt_s = RECV_B;
                end else begin
                    state_nxt_s = RECV_A;
                end
            end
            RECV_B: begin
                if (b_acc_s && b_last_s) begin
                    state_nxt_s = COMPUTE;
                end else begin
                    state_nxt_s = RECV_B;
                end
            end
            COMPUTE: begin
                if (Done) begin
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = COMPUTE;
                end
            end
            SEND: begin
                if (send_done_s) begin
                    state_nxt_s = RECV_A;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            default: begin
                state_nxt_s = RECV_A;
            end
        endcase
    end

    // Start is high exactly while the FSM sits in COMPUTE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_r <= 1'b0;
            rdy_r   <= 1'b0;
        end else begin
            start_r <= (state_nxt_s == COMPUTE);
            rdy_r   <= 1'b1;
        end
    end

    // A-matrix beat, column and per-bank address counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_cnt_r   <= {AW{1'b0}};
            j_r       <= {JW{1'b0}};
            a0_addr_r <= {A_depth_bits{1'b0}};
            a1_addr_r <= {A_depth_bits{1'b0}};
        end else if (a_acc_s) begin
            if (a_last_s) begin
                a_cnt_r   <= {AW{1'b0}};
                j_r       <= {JW{1'b0}};
                a0_addr_r <= {A_depth_bits{1'b0}};
                a1_addr_r <= {A_depth_bits{1'b0}};
            end else begin
                a_cnt_r <= a_cnt_r + AW'(1'b1);
                j_r     <= (j_r == JW'(N - 1)) ? {JW{1'b0}} : j_r + JW'(1'b1);
                if (a_lo_s) begin
                    a0_addr_r <= a0_addr_r + A_depth_bits'(1'b1);
                end else begin
                    a1_addr_r <= a1_addr_r + A_depth_bits'(1'b1);
                end
            end
        end
    end

    // B-matrix beat counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_cnt_r <= {BW{1'b0}};
        end else if (b_acc_s) begin
            b_cnt_r <= b_last_s ? {BW{1'b0}} : b_cnt_r + BW'(1'b1);
        end
    end

    // RES read sequencing and the two-entry output buffer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_r  <= {RW{1'b0}};
            out_cnt_r <= {RW{1'b0}};
            rd_pend_r <= 1'b0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
            buf_r[0]  <= {width{1'b0}};
            buf_r[1]  <= {width{1'b0}};
        end else if (send_done_s) begin
            rd_cnt_r  <= {RW{1'b0}};
            out_cnt_r <= {RW{1'b0}};
            rd_pend_r <= 1'b0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            occ_r     <= 2'd0;
        end else begin
            rd_pend_r <= rd_en_s;
            if (rd_en_s) begin
                rd_cnt_r <= rd_cnt_r + RW'(1'b1);
            end
            if (push_s) begin
                buf_r[wr_ptr_r] <= RES_read_data_out;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r  <= ~rd_ptr_r;
                out_cnt_r <= out_cnt_r + RW'(1'b1);
            end
            occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

`ifdef S_LAST_CHECK_EN
    logic err_r;

    // Sticky framing error: s_last must mark exactly the final beat of A and of B
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else if ((a_acc_s && (s_last != a_last_s)) || (b_acc_s && (s_last != b_last_s))) begin
            err_r <= 1'b1;
        end
    end

    assign err = err_r;
`else
    logic unused_s_last_s;

    assign unused_s_last_s = s_last;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_mm_stream_loader.sv
// Directed scoreboard bench for mm_stream_loader with M=2, N=4, P=2.
module tb_mm_stream_loader;
    localparam int W = 8;
    localparam int M = 2;
    localparam int N = 4;
    localparam int P = 2;
`ifdef S_LAST_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
    logic [W-1:0] s_data, m_data;
    logic A0_write_en, A1_write_en, B0_write_en, B1_write_en;
    logic [8:0] A0_write_address, A1_write_address, B0_write_address, B1_write_address;
    logic [W-1:0] A0_write_data_in, A1_write_data_in, B0_write_data_in, B1_write_data_in;
    logic Start, Done, RES_read_en, err;
    logic [8:0] RES_read_address;
    logic [W-1:0] RES_read_data_out;

    mm_stream_loader #(
        .width(W), .A_depth_bits(9), .B_depth_bits(9), .RES_depth_bits(9),
        .M(M), .N(N), .P(P)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .A0_write_en(A0_write_en), .A0_write_address(A0_write_address), .A0_write_data_in(A0_write_data_in),
        .A1_write_en(A1_write_en), .A1_write_address(A1_write_address), .A1_write_data_in(A1_write_data_in),
        .B0_write_en(B0_write_en), .B0_write_address(B0_write_address), .B0_write_data_in(B0_write_data_in),
        .B1_write_en(B1_write_en), .B1_write_address(B1_write_address), .B1_write_data_in(B1_write_data_in),
        .Start(Start), .Done(Done),
        .RES_read_en(RES_read_en), .RES_read_address(RES_read_address), .RES_read_data_out(RES_read_data_out),
        .err(err)
    );

    // Synchronous RES memory model and bank capture arrays
    logic [7:0] res_mem [0:511];
    logic [7:0] a0m [0:511];
    logic [7:0] a1m [0:511];
    logic [7:0] b0m [0:511];
    logic [7:0] b1m [0:511];
    logic clr_banks;

    always @(posedge clk) begin
        if (RES_read_en) RES_read_data_out <= res_mem[RES_read_address];
    end

    always @(posedge clk) begin
        if (clr_banks) begin
            for (int i = 0; i < 512; i++) begin
                a0m[i] <= 8'h00; a1m[i] <= 8'h00; b0m[i] <= 8'h00; b1m[i] <= 8'h00;
            end
        end else begin
            if (A0_write_en) a0m[A0_write_address] <= A0_write_data_in;
            if (A1_write_en) a1m[A1_write_address] <= A1_write_data_in;
            if (B0_write_en) b0m[B0_write_address] <= B0_write_data_in;
            if (B1_write_en) b1m[B1_write_address] <= B1_write_data_in;
        end
    end

    typedef struct packed { logic [3:0] en; logic [8:0] addr; logic [7:0] data; } wexp_t;
    typedef struct packed { logic [7:0] data; logic last; } mexp_t;
    wexp_t wq[$];
    mexp_t mq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] sel_addr(input logic [3:0] en);
        case (en)
            4'b0001: sel_addr = A0_write_address;
            4'b0010: sel_addr = A1_write_address;
            4'b0100: sel_addr = B0_write_address;
            4'b1000: sel_addr = B1_write_address;
            default: sel_addr = 9'h1ff;
        endcase
    endfunction

    function automatic logic [7:0] sel_data(input logic [3:0] en);
        case (en)
            4'b0001: sel_data = A0_write_data_in;
            4'b0010: sel_data = A1_write_data_in;
            4'b0100: sel_data = B0_write_data_in;
            4'b1000: sel_data = B1_write_data_in;
            default: sel_data = 8'hff;
        endcase
    endfunction

    function automatic logic ready_pat(input int mode, input int k);
        logic [5:0] pat;
        pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1
        if (mode == 0) ready_pat = 1'b1;
        else           ready_pat = pat[k % 6];
    endfunction

    task automatic drive_beat(input logic [7:0] d, input logic last, input wexp_t e);
        wexp_t x;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_last = last;
        wq.push_back(e);
        @(negedge clk);
        x = wq.pop_front();
        chk("wr_en", {B1_write_en, B0_write_en, A1_write_en, A0_write_en}, x.en);
        chk("wr_addr", sel_addr(x.en), x.addr);
        chk("wr_data", sel_data(x.en), x.data);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("stall_wr_en", {B1_write_en, B0_write_en, A1_write_en, A0_write_en}, 4'b0000);
    endtask

    // Sends A then B; abort_b >= 0 stops right after B beat abort_b is presented.
    task automatic send_frame(input int a_base, input int b_base, input int bad_idx,
                              input int gap, input int abort_b);
        wexp_t e;
        int i, j, k;
        for (int n = 0; n < M * N; n++) begin
            i = n / N; j = n % N;
            e.data = 8'(a_base + n);
            if (j < N / 2) begin e.en = 4'b0001; e.addr = 9'(i * (N / 2) + j); end
            else           begin e.en = 4'b0010; e.addr = 9'(i * (N / 2) + j - N / 2); end
            drive_beat(e.data, (n == M * N - 1) || (n == bad_idx), e);
            if (n == bad_idx)     chk("err_before_bad_last", err, 1'b0);
            if (n == bad_idx + 1) chk("err_after_bad_last", err, ERR_EXP);
            if (gap > 0 && (n % gap) == gap - 1 && n != M * N - 1) idle_cycle();
        end
        for (int n = 0; n < N * P; n++) begin
            j = n / P; k = n % P;
            e.data = 8'(b_base + n);
            if (j < N / 2) begin e.en = 4'b0100; e.addr = 9'(j * P + k); end
            else           begin e.en = 4'b1000; e.addr = 9'((j - N / 2) * P + k); end
            drive_beat(e.data, (n == N * P - 1), e);
            if (n == abort_b) return;
            if (gap > 0 && (n % gap) == gap - 1 && n != N * P - 1) idle_cycle();
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        chk("s_ready_compute", s_ready, 1'b0);
        chk("start_first_cycle", Start, 1'b1);
    endtask

    task automatic run_core_and_recv(input int mode);
        int k, first, lastk;
        m_ready = ready_pat(mode, 0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk("start_high", Start, 1'b1);
            chk("s_ready_compute_hold", s_ready, 1'b0);
            if (c == 5) Done = 1'b1;
        end
        @(negedge clk);
        Done = 1'b0;
        chk("start_fall", Start, 1'b0);
        chk("rd_en_first", RES_read_en, 1'b1);
        chk("rd_addr_first", RES_read_address, 9'd0);
        k = 0; first = -1; lastk = -1;
        while (mq.size() > 0 && k < 64) begin
            if (m_valid) begin
                if (first < 0) first = k;
                chk("m_data", m_data, mq[0].data);
                chk("m_last", m_last, mq[0].last);
                if (m_ready) begin
                    void'(mq.pop_front());
                    lastk = k;
                end
            end
            @(posedge clk); #1;
            k++;
            m_ready = ready_pat(mode, k);
            @(negedge clk);
        end
        chk("words_left", mq.size(), 0);
        if (mode == 0) begin
            chk("first_valid_latency", first, 2);
            chk("stream_span", lastk - first, M * P - 1);
        end
        chk("m_valid_after_send", m_valid, 1'b0);
        chk("s_ready_back_recv_a", s_ready, 1'b1);
        m_ready = 1'b0;
    endtask

    task automatic preload_res(input logic [7:0] base);
        mexp_t me;
        for (int i = 0; i < M * P; i++) begin
            res_mem[i] = base + 8'(i);
            me.data = base + 8'(i);
            me.last = (i == M * P - 1);
            mq.push_back(me);
        end
    endtask

    task automatic check_banks();
        int a0e[4] = '{1, 2, 5, 6};
        int a1e[4] = '{3, 4, 7, 8};
        for (int i = 0; i < 4; i++) begin
            chk("bank_a0", a0m[i], a0e[i]);
            chk("bank_a1", a1m[i], a1e[i]);
            chk("bank_b0", b0m[i], 9 + i);
            chk("bank_b1", b1m[i], 13 + i);
        end
    endtask

    initial begin
        resetn = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        m_ready = 1'b0; Done = 1'b0; clr_banks = 1'b1;
        #2;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_start", Start, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rd_en", RES_read_en, 1'b0);
        chk("rst_wr_en", {B1_write_en, B0_write_en, A1_write_en, A0_write_en}, 4'b0000);
        @(negedge clk);
        resetn = 1'b1; clr_banks = 1'b0;
        @(posedge clk); #1;
        chk("s_ready_after_release", s_ready, 1'b1);

        // Frame 1: constant s_valid, m_ready held high
        preload_res(8'hA0);
        send_frame(1, 9, -1, 0, -1);
        run_core_and_recv(0);
        check_banks();
        chk("err_clean_frame", err, 1'b0);

        // Frame 2: s_valid gaps and m_ready back-pressure
        preload_res(8'hB0);
        send_frame(8'h21, 8'h41, -1, 3, -1);
        run_core_and_recv(1);

        // Frame 3: reset during B beat 3
        send_frame(8'h61, 8'h71, -1, 0, 3);
        #1;
        resetn = 1'b0; clr_banks = 1'b1;
        #1;
        chk("midrst_wr_en", {B1_write_en, B0_write_en, A1_write_en, A0_write_en}, 4'b0000);
        chk("midrst_wr_addr", B0_write_address, 9'd0);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_start", Start, 1'b0);
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_rd_en", RES_read_en, 1'b0);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        resetn = 1'b1; clr_banks = 1'b0;
        @(posedge clk); #1;
        chk("s_ready_after_midrst", s_ready, 1'b1);

        // Frame 4: fresh full frame with a stray s_last on A beat index 5
        preload_res(8'hC0);
        send_frame(1, 9, 5, 2, -1);
        run_core_and_recv(1);
        check_banks();
        chk("err_sticky", err, ERR_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
